// File: rtl/reconf_lut_grid_pkg.sv
// Shared types and sizing helpers for the reconfigurable LUT grid.
// Config words are MSB-first: per LE func then sel3..sel0, then output selects, then pad.
package reconf_lut_grid_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int FUNC_W = 16;
  localparam int N_SEL  = 4;

  function automatic int sel_w(input int n_in, input int nle);
    int src;
    src = n_in + nle;
    return (src < 2) ? 1 : $clog2(src);
  endfunction

  function automatic int le_cfg_w(input int selw);
    return FUNC_W + N_SEL * selw;
  endfunction

  function automatic int cfg_bits(input int n_in, input int nle, input int n_out);
    return nle * le_cfg_w(sel_w(n_in, nle)) + n_out * sel_w(n_in, nle);
  endfunction

  function automatic int cfg_beats(input int bits, input int cfg_w);
    return (bits + cfg_w - 1) / cfg_w;
  endfunction

  // Field offsets inside one LE config word: func on top, sel0 at the LSB.
  function automatic int func_lsb(input int selw);
    return N_SEL * selw;
  endfunction

  function automatic int sel_lsb(input int k, input int selw);
    return k * selw;
  endfunction

endpackage

// File: rtl/reconf_le.sv
// One logic element: four source muxes feeding a 16-entry LUT, registered output.
module reconf_le
  import reconf_lut_grid_pkg::*;
#(
  parameter int SRC  = 6,
  parameter int SELW = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [SRC-1:0]               src,
  input  logic [FUNC_W+N_SEL*SELW-1:0] cfg,
  output logic                         q
);

  logic [FUNC_W-1:0] func;
  logic [N_SEL-1:0]  idx;

  assign func = cfg[func_lsb(SELW) +: FUNC_W];

  // Selects past the source space read as constant 0.
  for (genvar k = 0; k < N_SEL; k++) begin : g_sel
    logic [SELW-1:0] s;
    assign s      = cfg[sel_lsb(k, SELW) +: SELW];
    assign idx[k] = (int'(s) < SRC) ? src[s] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (en)  q <= func[idx];
  end

endmodule

// File: rtl/reconf_lut_grid.sv
// Grid of registered LUT elements loaded through a beat-serial config port.
// Sources are {le_q, in}; outputs pick any source combinationally while running.
module reconf_lut_grid
  import reconf_lut_grid_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic             en,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             running,
  output logic [N_OUT-1:0] out
);

  localparam int NLE   = ROWS * COLS;
  localparam int SRC   = N_IN + NLE;
  localparam int SELW  = sel_w(N_IN, NLE);
  localparam int LE_W  = le_cfg_w(SELW);
  localparam int BITS  = cfg_bits(N_IN, NLE, N_OUT);
  localparam int BEATS = cfg_beats(BITS, CFG_W);
  localparam int TOT   = BEATS * CFG_W;
  localparam int CNT_W = (BEATS < 2) ? 1 : $clog2(BEATS);

  state_t           state, state_nxt;
  logic             done_q, done_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TOT-1:0]   cfg_q;
  logic             beat, last_beat;
  logic             le_clr, le_en;
  logic [NLE-1:0]   le_q;
  logic [SRC-1:0]   src;

  // A restart wins over a beat presented in the same cycle.
  assign beat      = cfg_valid & (state == S_LOAD) & ~cfg_start;
  assign last_beat = beat & (int'(cnt) == BEATS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (cfg_start) begin
      state_nxt = S_LOAD;
    end else if (last_beat) begin
      state_nxt = S_RUN;
      done_nxt  = 1'b1;
    end
  end

  always_comb begin
    cfg_ready = (state == S_LOAD);
    running   = (state == S_RUN);
    cfg_done  = done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      cfg_q <= '0;
    end else if (cfg_start) begin
      cnt   <= '0;
      cfg_q <= '0;
    end else if (beat) begin
      cfg_q <= (cfg_q << CFG_W) | TOT'(cfg_data);
      cnt   <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  assign src    = {le_q, in};
  assign le_clr = (state != S_RUN) | cfg_start;
  assign le_en  = (state == S_RUN) & en;

  for (genvar k = 0; k < NLE; k++) begin : g_le
    reconf_le #(.SRC(SRC), .SELW(SELW)) u_le (
      .clk (clk),
      .rst (rst),
      .clr (le_clr),
      .en  (le_en),
      .src (src),
      .cfg (cfg_q[TOT-1-k*LE_W -: LE_W]),
      .q   (le_q[k])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic [SELW-1:0] osel;
    assign osel   = cfg_q[TOT-1-NLE*LE_W-j*SELW -: SELW];
    assign out[j] = (running && int'(osel) < SRC) ? src[osel] : 1'b0;
  end

  if (TOT > BITS) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^cfg_q[TOT-BITS-1:0];
  end

endmodule

// File: tb/tb_reconf_lut_grid.sv
// Scoreboarded random bench for reconf_lut_grid (1x2 grid, 2 inputs) plus a
// small directed check on a 3-input instance for out-of-range selects.
module tb_reconf_lut_grid;

  localparam int TOT   = 56;
  localparam int BEATS = 7;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  typedef struct packed {
    logic out;
    logic rdy;
    logic run;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] d_in = '0;
  logic       d_en = 1'b0, d_start = 1'b0, d_valid = 1'b0;
  logic [7:0] d_data = '0;
  logic       cfg_ready, cfg_done, running;
  logic [0:0] out;

  logic [2:0] b_in = '0;
  logic       b_en = 1'b0, b_start = 1'b0, b_valid = 1'b0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_done, b_running;
  logic [0:0] b_out;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  exp_t sbq[$];
  exp_t mon_x;

  // reference model state
  int         mode = M_IDLE;
  int         mcnt = 0;
  logic [7:0] mbeats[$];
  logic [1:0] mle = '0;
  logic       mdone = 1'b0;
  logic [15:0] mf[2];
  int         ms[2][4];
  int         mosel = 0;

  always #5 clk = ~clk;

  reconf_lut_grid #(.ROWS(1), .COLS(2), .N_IN(2), .N_OUT(1), .CFG_W(8)) u_dut (
    .clk(clk), .rst(rst), .in(d_in), .en(d_en), .cfg_start(d_start),
    .cfg_valid(d_valid), .cfg_data(d_data), .cfg_ready(cfg_ready),
    .cfg_done(cfg_done), .running(running), .out(out)
  );

  reconf_lut_grid #(.ROWS(1), .COLS(2), .N_IN(3), .N_OUT(1), .CFG_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .in(b_in), .en(b_en), .cfg_start(b_start),
    .cfg_valid(b_valid), .cfg_data(b_data), .cfg_ready(b_ready),
    .cfg_done(b_done), .running(b_running), .out(b_out)
  );

  always @(negedge clk) begin
    if (cfg_done) done_seen++;
    if (sbq.size() > 0) begin
      mon_x = sbq.pop_front();
      checks++;
      if ({out[0], cfg_ready, running, cfg_done} !== mon_x) begin
        errors++;
        $display("FAIL scoreboard t=%0t got out/rdy/run/done=%b%b%b%b want %b%b%b%b",
                 $time, out[0], cfg_ready, running, cfg_done,
                 mon_x.out, mon_x.rdy, mon_x.run, mon_x.done);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Packs a two-LE config MSB-first, then left-aligns it over the pad bits.
  function automatic logic [63:0] enc(input int selw, input int pad,
                                      input logic [15:0] f0, input logic [3:0][3:0] s0,
                                      input logic [15:0] f1, input logic [3:0][3:0] s1,
                                      input logic [3:0] osel);
    logic [63:0] v;
    v = 64'(f0);
    for (int m = 3; m >= 0; m--) v = (v << selw) | 64'(s0[m]);
    v = (v << 16) | 64'(f1);
    for (int m = 3; m >= 0; m--) v = (v << selw) | 64'(s1[m]);
    v = (v << selw) | 64'(osel);
    return v << pad;
  endfunction

  function automatic logic msrc(input int i, input logic [1:0] iv);
    if (i < 2) return iv[i];
    if (i < 4) return mle[i-2];
    return 1'b0;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; mcnt = 0; mbeats.delete(); mle = '0; mdone = 1'b0; mosel = 0;
  endtask

  task automatic model_decode();
    logic [55:0] c;
    int base;
    c = '0;
    foreach (mbeats[b]) c = (c << 8) | 56'(mbeats[b]);
    for (int k = 0; k < 2; k++) begin
      base = 55 - k * 24;
      mf[k] = c[base -: 16];
      for (int m = 0; m < 4; m++) ms[k][m] = int'(c[base-16-(3-m)*2 -: 2]);
    end
    mosel = int'(c[7:6]);
  endtask

  task automatic model_update(input logic [1:0] i, input logic e, input logic st,
                              input logic v, input logic [7:0] d);
    logic [1:0] nle;
    logic [3:0] idx;
    mdone = 1'b0;
    if (st) begin
      mode = M_LOAD; mcnt = 0; mbeats.delete(); mle = '0;
    end else if (mode == M_LOAD && v) begin
      mbeats.push_back(d);
      if (mcnt == BEATS - 1) begin
        mode = M_RUN; mdone = 1'b1; model_decode();
      end else mcnt++;
    end else if (mode == M_RUN && e) begin
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 4; m++) idx[m] = msrc(ms[k][m], i);
        nle[k] = mf[k][idx];
      end
      mle = nle;
    end
  endtask

  task automatic step(input logic [1:0] i, input logic e, input logic st,
                      input logic v, input logic [7:0] d);
    exp_t x;
    d_in = i; d_en = e; d_start = st; d_valid = v; d_data = d;
    x.rdy  = (mode == M_LOAD);
    x.run  = (mode == M_RUN);
    x.done = mdone;
    x.out  = (mode == M_RUN) ? msrc(mosel, i) : 1'b0;
    sbq.push_back(x);
    @(posedge clk);
    model_update(i, e, st, v, d);
    #1;
  endtask

  task automatic rstep(input int n, input bit en_rand);
    for (int t = 0; t < n; t++)
      step(2'($urandom_range(0, 3)), en_rand ? 1'($urandom_range(0, 1)) : 1'b1,
           1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic load(input logic [63:0] cv, input bit gaps);
    step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 8'h00);
    for (int b = 0; b < BEATS; b++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int t = 0; t < g; t++)
          step(2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 8'($urandom));
      end
      step(2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1, cv[TOT-1-8*b -: 8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] cv;
    int d0;
    model_reset();
    #2;
    chk("reset_ready", 8'(cfg_ready), 8'h0);
    chk("reset_running", 8'(running), 8'h0);
    chk("reset_done", 8'(cfg_done), 8'h0);
    chk("reset_out", 8'(out), 8'h0);
    chk("reset_b_out", 8'(b_out), 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // out-of-range selects on the 3-input instance: LUT index 0 -> func bit 0
    cv = enc(3, 5, 16'h0001, {4'd7, 4'd7, 4'd7, 4'd7}, 16'h0001,
             {4'd7, 4'd7, 4'd7, 4'd7}, 4'd3);
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    chk("b_ready_load", 8'(b_ready), 8'h1);
    for (int b = 0; b < 8; b++) begin
      b_valid = 1'b1; b_data = cv[63-8*b -: 8];
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    chk("b_running", 8'(b_running), 8'h1);
    chk("b_done", 8'(b_done), 8'h1);
    chk("b_out_prestep", 8'(b_out), 8'h0);
    b_en = 1'b1; b_in = 3'b101; @(posedge clk); #1; b_en = 1'b0;
    chk("b_out_oor", 8'(b_out), 8'h1);
    chk("b_done_once", 8'(b_done), 8'h0);

    // reset in the middle of a load
    step(2'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int b = 0; b < 3; b++) step(2'd1, 1'b1, 1'b0, 1'b1, 8'hFF);
    rst = 1'b1; model_reset();
    #1;
    chk("midload_rst_ready", 8'(cfg_ready), 8'h0);
    chk("midload_rst_out", 8'(out), 8'h0);
    chk("midload_rst_running", 8'(running), 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2'd3, 1'b1, 1'b0, 1'b1, 8'hA5);

    // in[0] buffer through LE0
    load(enc(2, 6, 16'hAAAA, {4'd1, 4'd1, 4'd1, 4'd0}, 16'h0000, 16'h0, 4'd2), 1'b0);
    rstep(20, 1'b0);

    // self-loop toggle, random enable
    load(enc(2, 6, 16'h5555, {4'd0, 4'd0, 4'd0, 4'd2}, 16'hFFFF, 16'h0, 4'd2), 1'b0);
    rstep(6, 1'b0);
    rstep(20, 1'b1);

    // two-stage chain
    load(enc(2, 6, 16'hAAAA, {4'd0, 4'd0, 4'd0, 4'd0},
             16'hAAAA, {4'd0, 4'd0, 4'd0, 4'd2}, 4'd3), 1'b0);
    rstep(20, 1'b0);

    // restart during RUN, then a gapped load; cfg_done must pulse once
    step(2'd0, 1'b1, 1'b1, 1'b0, 8'h00);
    d0 = done_seen;
    load(enc(2, 6, 16'h6996, {4'd3, 4'd2, 4'd1, 4'd0},
             16'h8E71, {4'd0, 4'd1, 4'd2, 4'd3}, 4'd3), 1'b1);
    rstep(4, 1'b1);
    chk("done_pulse_count", 8'(done_seen - d0), 8'h1);

    // random configurations
    for (int r = 0; r < 6; r++) begin
      logic [3:0][3:0] sa, sb;
      for (int m = 0; m < 4; m++) begin
        sa[m] = 4'($urandom_range(0, 3));
        sb[m] = 4'($urandom_range(0, 3));
      end
      load(enc(2, 6, 16'($urandom), sa, 16'($urandom), sb, 4'($urandom_range(0, 3))), r[0]);
      rstep(25, 1'b1);
    end

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 8'(sbq.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reconf_lut_grid.md
RECONF_LUT_GRID -- requirements
Module: reconf_lut_grid

Interface
- REQ-001 Parameter ROWS, default 5: logic-element (LE) grid rows.
- REQ-002 Parameter COLS, default 5: LE grid columns; NLE = ROWS*COLS.
- REQ-003 Parameter N_IN, default 4: primary input width.
- REQ-004 Parameter N_OUT, default 1: primary output width.
- REQ-005 Parameter CFG_W, default 8: configuration word width per beat.
- REQ-006 clk  input  1  sole clock; all state on rising edge.
- REQ-007 rst  input  1  asynchronous, active-high reset.
- REQ-008 in  input  N_IN  primary inputs, sampled each stepping edge.
- REQ-009 en  input  1  step enable in RUN.
- REQ-010 cfg_start  input  1  pulse: discard config, enter LOAD.
- REQ-011 cfg_valid  input  1  cfg_data valid.
- REQ-012 cfg_data  input  CFG_W  configuration word.
- REQ-013 cfg_ready  output  1  high only in LOAD.
- REQ-014 cfg_done  output  1  one-cycle pulse on LOAD->RUN.
- REQ-015 running  output  1  high in RUN.
- REQ-016 out  output  N_OUT  selected source values.

Function
- REQ-017 Source space: SRC = N_IN+NLE; SELW = clog2(SRC); index i<N_IN is in[i], N_IN<=i<SRC is le_q[i-N_IN], i>=SRC is constant 0.
- REQ-018 LE config: 16-bit func plus four SELW-bit selects sel3..sel0; LE next = func[{s3,s2,s1,s0}], s3 MSB.
- REQ-019 Every LE output is registered (le_q); feedback and self-loops are legal, no combinational loops exist.
- REQ-020 CFG_BITS = NLE*(16+4*SELW) + N_OUT*SELW, padded with zeros at the LSB end to CFG_BEATS*CFG_W.
- REQ-021 Layout, MSB first: LE0 func, LE0 sel3..sel0, LE1 ..., LE(NLE-1), then OSEL0..OSEL(N_OUT-1), then pad.
- REQ-022 Each accepted beat (cfg_valid & cfg_ready) shifts cfg_data into the config register LSB end; first beat ends most significant.
- REQ-023 States: IDLE (after reset), LOAD, RUN.
- REQ-024 IDLE: cfg_start -> LOAD; beat counter cleared.
- REQ-025 LOAD: counter increments per accepted beat; accepting beat CFG_BEATS-1 -> RUN next cycle with cfg_done high for that one cycle.
- REQ-026 cfg_start in LOAD or RUN: restart LOAD, counter cleared, le_q cleared; takes priority over a same-cycle beat, which is dropped.
- REQ-027 In IDLE and LOAD, le_q holds 0 and out = 0.
- REQ-028 In RUN with en=1, all le_q update simultaneously from previous le_q and current in; en=0 holds le_q.
- REQ-029 out[j] = source OSELj, combinational from le_q and in (one-step latency from in through one LE).
- REQ-030 cfg_ready low outside LOAD; beats outside LOAD ignored.

Reset
- REQ-031 rst forces IDLE, le_q = 0, config register = 0, beat counter = 0, cfg_ready = 0, cfg_done = 0, running = 0, out = 0, immediately and asynchronously.
- REQ-032 rst mid-LOAD discards partial config; new cfg_start is required.

Structure
- REQ-033 Shared package holds the state enum, SELW/CFG_BITS/CFG_BEATS computation functions and the LE config field offsets.
- REQ-034 One sub-module: reconf_le (16-bit LUT, four SELW-bit source muxes, output register with enable and clear), instantiated NLE times via generate.

Verification (ROWS=1, COLS=2, N_IN=2, N_OUT=1, CFG_W=8 unless noted)
- REQ-035 Reset mid-LOAD after 3 beats -> IDLE, cfg_ready=0, out=0; load after fresh cfg_start completes normally.
- REQ-036 LE0 func=16'hAAAA, sel0=in[0]; OSEL0=LE0; RUN, en=1, toggle in[0] -> out follows in[0] exactly one edge later.
- REQ-037 LE0 func=16'h5555, sel0=LE0 (self-loop) -> out toggles 0,1,0,1 each en=1 edge; holds while en=0.
- REQ-038 Chain LE0=in[0] buffer, LE1=buffer of LE0, OSEL0=LE1 -> out lags in[0] by two edges.
- REQ-039 Select index >= SRC on all LE inputs, func=16'h0001 -> out=1 after first step.
- REQ-040 cfg_start during RUN -> out=0 next cycle, cfg_ready=1; cfg_done pulses exactly once after CFG_BEATS beats with cfg_valid gaps inserted.
